// File: rtl/alu_share_ctrl_if.sv
// Request/response and ALU-side signal bundle for alu_share_ctrl.
// The slave modport is the controller; the master modport is the surrounding pipeline and ALU.
interface alu_share_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2:0]            req0_op;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic                  rsp0_valid;
    logic                  rsp0_ready;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [2:0]            req1_op;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic                  rsp1_valid;
    logic                  rsp1_ready;

    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_zero;
    logic                  rsp_err;

    logic                  alu_en;
    logic [2:0]            alu_control;
    logic [DATA_WIDTH-1:0] alu_srca;
    logic [DATA_WIDTH-1:0] alu_srcb;
    logic [DATA_WIDTH-1:0] alu_y;

    logic                  busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  alu_y,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_data, rsp_zero, rsp_err,
        output alu_en, alu_control, alu_srca, alu_srcb, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output alu_y,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_data, rsp_zero, rsp_err,
        input  alu_en, alu_control, alu_srca, alu_srcb, busy
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one single-cycle ALU between execute (req0) and branch/address (req1).
// One operation in flight; the response is held until its owner takes it.
//
// state | meaning
// IDLE  | waiting for a request; grant is given combinationally
// EXEC  | ALU driven from latched operands for one cycle; result captured
// RESP  | response presented to the granted requester until taken
module alu_share_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic                  ptr;
    logic                  gnt_id;
    logic                  sel_valid;
    logic                  sel_id;
    logic                  take;
    logic                  rsp_taken;
    logic [2:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_zero_q;
    logic                  rsp_err_q;
    logic                  alu_en_q;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] srca_q;
    logic [DATA_WIDTH-1:0] srcb_q;

    function automatic logic op_legal(input logic [2:0] op);
        return (op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
    endfunction

    // With both requesters valid the pointer decides; otherwise the lone valid one wins.
    always_comb begin
        sel_valid = bus.req0_valid | bus.req1_valid;
        sel_id    = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
        sel_op    = sel_id ? bus.req1_op : bus.req0_op;
        sel_a     = sel_id ? bus.req1_a  : bus.req0_a;
        sel_b     = sel_id ? bus.req1_b  : bus.req0_b;
        take      = (state == IDLE) & sel_valid & ~rst;
        rsp_taken = gnt_id ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready  = take & ~sel_id;
    assign bus.req1_ready  = take & sel_id;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_control = ctrl_q;
    assign bus.alu_srca    = srca_q;
    assign bus.alu_srcb    = srcb_q;
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            gnt_id       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_en_q     <= 1'b0;
            ctrl_q       <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        gnt_id   <= sel_id;
                        ctrl_q   <= sel_op;
                        srca_q   <= sel_a;
                        srcb_q   <= sel_b;
                        alu_en_q <= op_legal(sel_op);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    alu_en_q <= 1'b0;
                    // Illegal ops never reach the ALU; report a forced zero result instead.
                    if (op_legal(ctrl_q)) begin
                        rsp_data_q <= bus.alu_y;
                        rsp_zero_q <= (bus.alu_y == '0);
                        rsp_err_q  <= 1'b0;
                    end else begin
                        rsp_data_q <= '0;
                        rsp_zero_q <= 1'b1;
                        rsp_err_q  <= 1'b1;
                    end
                    rsp0_valid_q <= ~gnt_id;
                    rsp1_valid_q <= gnt_id;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        ptr          <= ~gnt_id;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed vector table, hand-written stall/reset
// sequences, and randomized two-requester traffic against an in-bench reference model.
module tb_alu_share_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    alu_share_ctrl #(.DATA_WIDTH(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-cycle ALU; junk on illegal codes so a leaked alu_y is visible.
    always_comb begin
        case (bus.alu_control)
            3'b000:  bus.alu_y = bus.alu_srca + bus.alu_srcb;
            3'b001:  bus.alu_y = bus.alu_srca - bus.alu_srcb;
            3'b010:  bus.alu_y = bus.alu_srca & bus.alu_srcb;
            3'b011:  bus.alu_y = bus.alu_srca | bus.alu_srcb;
            3'b101:  bus.alu_y = ($signed(bus.alu_srca) < $signed(bus.alu_srcb)) ? 32'd1 : 32'd0;
            default: bus.alu_y = 32'hDEAD_BEEF;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: {err, zero, data} computed from the op semantics.
    function automatic logic [DW+1:0] ref_rsp(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] d;
        case (op)
            3'b000:  d = a + b;
            3'b001:  d = a - b;
            3'b010:  d = a & b;
            3'b011:  d = a | b;
            3'b101:  d = ($signed(a) < $signed(b)) ? 1 : 0;
            default: return {1'b1, 1'b1, {DW{1'b0}}};
        endcase
        return {1'b0, (d == 0), d};
    endfunction

    task automatic drive_req(input int id, input logic v, input logic [2:0] op,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return bus.req0_ready;
            1:       return bus.req1_ready;
            2:       return bus.rsp0_valid;
            default: return bus.rsp1_valid;
        endcase
    endfunction

    // Returns at the negedge where the signal is seen high, or after maxc cycles.
    task automatic wait_sig(input int which, input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (get_sig(which)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_req(0, 1'b0, 3'd0, '0, '0);
        drive_req(1, 1'b0, 3'd0, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        int            id;
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] y;
        logic          z;
        logic          e;
    } vec_t;

    vec_t vecs[11];

    task automatic single_op(input vec_t v, input int idx);
        int t_rdy = 0, t_vld = 0, en_cnt = 0, rdy_cnt = 0;
        bit got_rdy = 0, got_vld = 0;
        logic [DW-1:0] d = '0, srca_seen = '0;
        logic z = 0, e = 0, other = 0;
        string tag = $sformatf("vec%0d", idx);
        @(posedge clk); #1;
        drive_req(v.id, 1'b1, v.op, v.a, v.b);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && !got_vld; cyc++) begin
            @(negedge clk);
            if (get_sig(v.id)) begin
                rdy_cnt++;
                if (!got_rdy) t_rdy = cyc;
                got_rdy = 1;
            end
            if (bus.alu_en) begin
                en_cnt++;
                srca_seen = bus.alu_srca;
            end
            if (get_sig(2 + v.id)) begin
                got_vld = 1;
                t_vld   = cyc;
                d       = bus.rsp_data;
                z       = bus.rsp_zero;
                e       = bus.rsp_err;
                other   = get_sig(3 - v.id);
            end
            @(posedge clk); #1;
            if (got_rdy) drive_req(v.id, 1'b0, 3'd0, '0, '0);
        end
        chk({tag, "_rsp_seen"}, got_vld, 1);
        chk({tag, "_ready_pulses"}, rdy_cnt, 1);
        chk({tag, "_latency"}, t_vld - t_rdy, 2);
        chk({tag, "_alu_en_cycles"}, en_cnt, v.e ? 0 : 1);
        if (!v.e) chk({tag, "_alu_srca"}, srca_seen, v.a);
        chk({tag, "_rsp_data"}, d, v.y);
        chk({tag, "_rsp_zero"}, z, v.z);
        chk({tag, "_rsp_err"}, e, v.e);
        chk({tag, "_other_valid"}, other, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    // Randomized / round-robin traffic with a queue-based reference.
    logic [2:0]    opl[2][64];
    logic [DW-1:0] al[2][64];
    logic [DW-1:0] bl[2][64];
    logic [DW+1:0] expq[2][$];

    task automatic run_stream(input int nops, input bit rand_rdy, input bit rand_valid,
                              input string tag);
        int  issued[2] = '{0, 0};
        int  done[2]   = '{0, 0};
        bit  pend[2]   = '{0, 0};
        bit  model_ptr = 0;
        int  idx, g;
        logic r0, r1, both;
        logic [DW+1:0] ex, act;
        for (int n = 0; n < 2; n++) begin
            expq[n].delete();
            for (int k = 0; k < nops; k++) begin
                opl[n][k] = 3'($urandom_range(0, 7));
                al[n][k]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
                bl[n][k]  = ($urandom_range(0, 3) == 0) ? al[n][k] : $urandom;
            end
        end
        for (int cyc = 0; cyc < nops * 40 + 50; cyc++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && issued[n] < nops && (!rand_valid || $urandom_range(0, 1) == 1))
                    pend[n] = 1;
                idx = (issued[n] < nops) ? issued[n] : 0;
                drive_req(n, pend[n], opl[n][idx], al[n][idx], bl[n][idx]);
            end
            bus.rsp0_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rsp1_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            r0   = bus.req0_ready;
            r1   = bus.req1_ready;
            both = pend[0] && pend[1];
            if (r0 || r1) begin
                g = r1 ? 1 : 0;
                chk({tag, "_ready_onehot"}, r0 & r1, 0);
                chk({tag, "_ready_needs_valid"}, pend[g], 1);
                chk({tag, "_one_in_flight"}, (issued[0] + issued[1]) - (done[0] + done[1]), 0);
                if (both) chk({tag, "_rr_grant"}, g, model_ptr);
                expq[g].push_back(ref_rsp(opl[g][issued[g]], al[g][issued[g]], bl[g][issued[g]]));
                issued[g]++;
                pend[g] = 0;
            end
            if (bus.rsp0_valid || bus.rsp1_valid)
                chk({tag, "_rsp_valid_onehot"}, bus.rsp0_valid & bus.rsp1_valid, 0);
            for (int n = 0; n < 2; n++) begin
                if (get_sig(2 + n) && (n == 0 ? bus.rsp0_ready : bus.rsp1_ready)) begin
                    if (expq[n].size() == 0) begin
                        chk({tag, "_rsp_expected"}, expq[n].size(), 1);
                    end else begin
                        ex  = expq[n].pop_front();
                        act = {bus.rsp_err, bus.rsp_zero, bus.rsp_data};
                        chk($sformatf("%s_rsp%0d_result", tag, n), act, ex);
                        done[n]++;
                        model_ptr = (n == 0);
                    end
                end
            end
            if (done[0] == nops && done[1] == nops) break;
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, '0, '0);
        drive_req(1, 1'b0, 3'd0, '0, '0);
        chk({tag, "_rsp0_count"}, done[0], nops);
        chk({tag, "_rsp1_count"}, done[1], nops);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0]  = '{0, 3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{0, 3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0};
        vecs[2]  = '{1, 3'b001, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[3]  = '{1, 3'b110, 32'd1234,       32'd5678,       32'd0,          1'b1, 1'b1};
        vecs[4]  = '{0, 3'b010, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0};
        vecs[5]  = '{1, 3'b011, 32'd0,          32'd0,          32'd0,          1'b1, 1'b0};
        vecs[6]  = '{0, 3'b101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[7]  = '{1, 3'b101, 32'd5,          32'hFFFF_FFFE,  32'd0,          1'b1, 1'b0};
        vecs[8]  = '{0, 3'b100, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
        vecs[9]  = '{1, 3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[10] = '{0, 3'b111, 32'd7,          32'd7,          32'd0,          1'b1, 1'b1};

        // Reset state, with a request already pending during reset.
        drive_req(0, 1'b1, 3'b000, 32'd1, 32'd1);
        drive_req(1, 1'b0, 3'b000, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",        bus.busy, 0);
        chk("rst_req0_ready",  bus.req0_ready, 0);
        chk("rst_req1_ready",  bus.req1_ready, 0);
        chk("rst_rsp_valids",  {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_rsp_fields",  {bus.rsp_err, bus.rsp_zero, bus.rsp_data}, 0);
        chk("rst_alu_en",      bus.alu_en, 0);
        chk("rst_alu_fields",  {bus.alu_control, bus.alu_srca, bus.alu_srcb}, 0);
        do_reset();

        for (int i = 0; i < 11; i++) single_op(vecs[i], i);

        // Round robin with both requesters continuously valid.
        do_reset();
        run_stream(4, 1'b0, 1'b0, "rr");

        // Response stall while the other requester waits.
        do_reset();
        @(posedge clk); #1;
        drive_req(0, 1'b1, 3'b000, 32'd100, 32'd23);
        wait_sig(0, 10, seen);
        chk("stall_req0_grant", seen, 1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, '0, '0);
        drive_req(1, 1'b1, 3'b001, 32'd50, 32'd8);
        wait_sig(2, 10, seen);
        chk("stall_rsp0_seen", seen, 1);
        chk("stall_req1_ready_0", bus.req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("stall_data_held_%0d", i), bus.rsp_data, 32'd123);
            chk($sformatf("stall_rsp0_valid_%0d", i), bus.rsp0_valid, 1);
            chk($sformatf("stall_req1_blocked_%0d", i), bus.req1_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("stall_req1_not_yet", bus.req1_ready, 0);
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        chk("stall_req1_granted", bus.req1_ready, 1);
        chk("stall_rsp0_dropped", bus.rsp0_valid, 0);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 3'd0, '0, '0);
        bus.rsp1_ready = 1'b1;
        wait_sig(3, 10, seen);
        chk("stall_rsp1_seen", seen, 1);
        chk("stall_rsp1_data", bus.rsp_data, 32'd42);
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b0;

        // Reset during EXEC discards the op; re-grant starts from pointer 0.
        do_reset();
        single_op(vecs[0], 100);
        @(posedge clk); #1;
        drive_req(0, 1'b1, 3'b000, 32'd1, 32'd2);
        drive_req(1, 1'b1, 3'b011, 32'd3, 32'd4);
        @(negedge clk);
        chk("rexec_ptr1_req1", bus.req1_ready, 1);
        chk("rexec_ptr1_req0", bus.req0_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rexec_alu_en", bus.alu_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rexec_busy", bus.busy, 0);
        chk("rexec_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rexec_alu_en_off", bus.alu_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rexec_regrant_req0", bus.req0_ready, 1);
        chk("rexec_regrant_req1", bus.req1_ready, 0);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, '0, '0);
        drive_req(1, 1'b0, 3'd0, '0, '0);
        wait_sig(2, 10, seen);
        chk("rexec_rsp0_seen", seen, 1);
        chk("rexec_rsp0_data", bus.rsp_data, 32'd3);
        @(posedge clk); #1;

        // Randomized traffic with random valid gaps and response back-pressure.
        do_reset();
        run_stream(30, 1'b1, 1'b1, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
